fb_line_fetch_scheduler: RTL and testbench
==========================================

Name: fb_line_fetch_scheduler

Overview:
- Sequences the AXI burst reads for the dual-layer framebuffer reader.
- On each line request it issues 10 single-outstanding read bursts to the AXI burst engine: 5 for layer FB0, then 5 for layer FB1.
- It computes every burst address from layer, display bank (double buffering) and line number.
- It shares the single AR/R path with the audio sample fetcher by inserting audio bursts in the gaps between video bursts.

Parameters:
- FB0_ADDR, 32'h81000000, layer 0 base, bank 0
- FB1_ADDR, 32'h8112C000, layer 1 base, bank 0
- FB0_ALT_ADDR, 32'h81258000, layer 0 base, bank 1
- FB1_ALT_ADDR, 32'h81384000, layer 1 base, bank 1
- LINE_STRIDE, 32'hA00, bytes per line (640 px x 4 B)
- BURST_BYTES, 32'h200, bytes per video burst (64 beats x 8 B)
- BURSTS_PER_LINE, 5, video bursts per layer per line
- LINES, 480, valid line count
- VIDEO_LEN, 8'd63, arlen for video bursts
- AUDIO_LEN, 8'd15, arlen for audio bursts

Ports:
- m00_axi_aclk  in  1  clock
- m00_axi_areset  in  1  synchronous, active-high reset
- line_req  in  1  pulse: fetch line line_num
- line_num  in  9  line index, sampled with line_req
- frame_start  in  1  pulse at start of frame (vc wrap)
- flip_req  in  1  pulse: swap display bank at next frame_start
- burst_valid  out  1  burst command valid
- burst_ready  in  1  burst engine accepts command
- burst_addr  out  32  byte address of burst
- burst_len  out  8  arlen
- burst_layer  out  1  0=FB0, 1=FB1 (selects BRAM)
- burst_index  out  3  burst number within layer, 0..4
- burst_is_audio  out  1  command belongs to audio
- burst_done  in  1  pulse: rlast beat accepted
- audio_req  in  1  level: audio fetch pending
- audio_addr  in  32  audio burst address
- audio_grant  out  1  pulse on audio command handshake
- line_busy  out  1  a video line is in progress
- line_done  out  1  pulse when 10th video burst_done arrives
- cur_bank  out  1  bank currently displayed
- flip_done  out  1  pulse when bank swap is applied
- line_err  out  1  sticky: overrun or line_num >= LINES

Behaviour:
- Reset (sync, active-high): all outputs 0, cur_bank=0, flip pending cleared, state IDLE. A reset mid-burst abandons the sequence; the burst engine is reset by the same signal.
- States:
  - IDLE -> V_ISSUE on an accepted line_req.
  - IDLE -> A_ISSUE if audio_req and no line_req that cycle. line_req wins on a simultaneous event; audio is served in the gaps.
  - V_ISSUE -> V_WAIT on valid&&ready.
  - A_ISSUE -> A_WAIT on valid&&ready.
  - V_WAIT on burst_done:
    - if it was the last burst (layer 1, index 4): line_done pulse, -> IDLE;
    - else if audio_req: -> A_ISSUE;
    - else: -> V_ISSUE with the next burst.
  - A_WAIT on burst_done: -> V_ISSUE if the line is unfinished, else IDLE.
- Fairness: at most one audio burst between consecutive video bursts.
- line_req acceptance and latency:
  - Accepted only when line_busy=0 and line_num < LINES.
  - line_busy and burst_valid rise the cycle after acceptance.
  - line_num and bank are snapshotted at acceptance.
  - A flip applied mid-line does not affect the current line.
- Rejected line_req: line_err set sticky, no bursts issued, and the current line continues unaffected.
- Burst order: layer 0 indices 0..4, then layer 1 indices 0..4.
- Address: base(layer, bank) + line*LINE_STRIDE + index*BURST_BYTES, in 32-bit unsigned arithmetic with no wrap handling needed. The maximum value is 0x814AFE00.
- Audio commands: burst_addr=audio_addr (sampled at issue), burst_len=AUDIO_LEN, burst_is_audio=1, burst_layer=0, burst_index=0.
- burst_valid/addr/len/layer/index/is_audio are registered and held stable until the handshake. burst_valid drops the cycle after the handshake. Exactly one command is outstanding at a time.
- burst_done in IDLE or an ISSUE state is ignored.
- Bank flip:
  - flip_req sets a pending flag; a repeated flip_req while pending has no extra effect.
  - On frame_start with the flag pending: cur_bank toggles, flip_done pulses 1 cycle later than frame_start (registered), and the flag clears.
  - flip_req and frame_start in the same cycle: the flip applies at that frame_start.

Decomposition:
- fbreader_pkg: the four base addresses, LINE_STRIDE, BURST_BYTES, BURSTS_PER_LINE, LINES, and the state enum (IDLE, V_ISSUE, V_WAIT, A_ISSUE, A_WAIT). This package is shared with the M00_AXI master and the testbench.
- Sub-module fb_burst_addr_gen: registered address computation from (layer, bank, line, index). The line*0xA00 term is computed as shift-adds, (line<<11)+(line<<9), with no multiplier.

Test Plan:
- Reset, line_req with line_num=0, bank 0, burst_ready=1, burst_done 4 cycles after each handshake -> addresses 0x81000000, 0x81000200 .. 0x81000800, then 0x8112C000 .. 0x8112C800; len 63; one line_done pulse after the 10th done.
- flip_req, frame_start, then line_req with line_num=479 -> cur_bank=1, flip_done pulse; the last command is 0x814AFE00 with layer=1, index=4.
- audio_req held high with audio_addr=0x80F00000 during a line -> the order alternates V, A, V, A … with audio len 15 and 9 audio_grant pulses; the video address sequence is unchanged.
- line_req during line_busy, and separately line_req with line_num=480 -> line_err=1, no extra commands, the in-flight line completes normally.
- burst_ready held low for 20 cycles -> burst_valid and burst_addr are stable throughout; the handshake occurs on the first ready.
- Reset asserted in V_WAIT after 3 bursts -> all outputs 0 the next cycle; a new line_req with line_num=2 restarts at 0x81001400.

Source files
------------

// File: rtl/fbreader_pkg.sv
// Shared constants, FSM state encoding and burst command payload for the
// dual-layer framebuffer reader (scheduler, M00_AXI master, testbench).
package fbreader_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 9;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned LEN_W  = 8;

  localparam logic [ADDR_W-1:0] FB0_ADDR     = 32'h8100_0000;
  localparam logic [ADDR_W-1:0] FB1_ADDR     = 32'h8112_C000;
  localparam logic [ADDR_W-1:0] FB0_ALT_ADDR = 32'h8125_8000;
  localparam logic [ADDR_W-1:0] FB1_ALT_ADDR = 32'h8138_4000;
  localparam logic [ADDR_W-1:0] LINE_STRIDE  = 32'h0000_0A00;
  localparam logic [ADDR_W-1:0] BURST_BYTES  = 32'h0000_0200;

  localparam int unsigned BURSTS_PER_LINE = 5;
  localparam int unsigned LINES           = 480;

  localparam logic [LEN_W-1:0] VIDEO_LEN = 8'd63;
  localparam logic [LEN_W-1:0] AUDIO_LEN = 8'd15;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    V_ISSUE = 3'd1,
    V_WAIT  = 3'd2,
    A_ISSUE = 3'd3,
    A_WAIT  = 3'd4
  } state_e;

  // Command attributes held alongside burst_addr until the handshake
  typedef struct packed {
    logic             is_audio;
    logic             layer;
    logic [IDX_W-1:0] index;
    logic [LEN_W-1:0] len;
  } burst_cmd_t;

  // Layer base address for the selected display bank
  function automatic logic [ADDR_W-1:0] base_addr(input logic layer, input logic bank);
    case ({bank, layer})
      2'b00:   return FB0_ADDR;
      2'b01:   return FB1_ADDR;
      2'b10:   return FB0_ALT_ADDR;
      default: return FB1_ALT_ADDR;
    endcase
  endfunction

endpackage

// File: rtl/fb_line_fetch_scheduler_if.sv
// Burst command / completion bus between the line fetch scheduler (master)
// and the AXI burst engine (slave).
//   burst_valid/addr/len/layer/index/is_audio : command, held until ready
//   burst_ready : engine accepts the command
//   burst_done  : pulse when the rlast beat of the outstanding burst is taken
interface fb_line_fetch_scheduler_if;
  import fbreader_pkg::*;

  logic                 burst_valid;
  logic                 burst_ready;
  logic [ADDR_W-1:0]    burst_addr;
  logic [LEN_W-1:0]     burst_len;
  logic                 burst_layer;
  logic [IDX_W-1:0]     burst_index;
  logic                 burst_is_audio;
  logic                 burst_done;

  modport master (
    output burst_valid, burst_addr, burst_len, burst_layer, burst_index, burst_is_audio,
    input  burst_ready, burst_done
  );

  modport slave (
    input  burst_valid, burst_addr, burst_len, burst_layer, burst_index, burst_is_audio,
    output burst_ready, burst_done
  );

endinterface

// File: rtl/fb_burst_addr_gen.sv
// Registered burst address: loads either the audio address or
// base(layer, bank) + line*0xA00 + index*0x200 when load is set, else holds.
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture a new command address
//   sel_audio  : capture audio_addr instead of the video address
//   layer/bank/line/index : video burst coordinates
//   addr       : registered burst address
module fb_burst_addr_gen
  import fbreader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              sel_audio,
  input  logic [ADDR_W-1:0] audio_addr,
  input  logic              layer,
  input  logic              bank,
  input  logic [LINE_W-1:0] line,
  input  logic [IDX_W-1:0]  index,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] line_off, idx_off;

  // 0xA00 = 2^11 + 2^9, so the stride product is two shifted copies
  always_comb begin
    line_off = (ADDR_W'(line) << 11) + (ADDR_W'(line) << 9);
    idx_off  = ADDR_W'(index) << 9;
    addr_d   = addr_q;
    if (load) begin
      addr_d = sel_audio ? audio_addr : base_addr(layer, bank) + line_off + idx_off;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) addr_q <= '0;
    else     addr_q <= addr_d;
  end

  assign addr = addr_q;

endmodule

// File: rtl/fb_line_fetch_scheduler.sv
// Line fetch scheduler: per line request issues 5 FB0 then 5 FB1 video
// bursts, one outstanding at a time, interleaving at most one audio burst
// between consecutive video bursts; also manages the double-buffer bank flip.
//   m00_axi_aclk/areset : clock, synchronous active-high reset
//   line_req/line_num   : fetch request and line index
//   frame_start/flip_req: frame boundary and bank swap request
//   bus                 : burst command/completion bus (master side)
//   audio_req/addr/grant: audio fetcher request, address, grant pulse
//   line_busy/line_done : line in progress / completion pulse
//   cur_bank/flip_done  : displayed bank / swap-applied pulse
//   line_err            : sticky overrun or out-of-range line request
module fb_line_fetch_scheduler
  import fbreader_pkg::*;
(
  input  logic                        m00_axi_aclk,
  input  logic                        m00_axi_areset,
  input  logic                        line_req,
  input  logic [LINE_W-1:0]           line_num,
  input  logic                        frame_start,
  input  logic                        flip_req,
  fb_line_fetch_scheduler_if.master   bus,
  input  logic                        audio_req,
  input  logic [ADDR_W-1:0]           audio_addr,
  output logic                        audio_grant,
  output logic                        line_busy,
  output logic                        line_done,
  output logic                        cur_bank,
  output logic                        flip_done,
  output logic                        line_err
);

  state_e            state_q, state_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              line_bank_q, line_bank_d;
  logic              vid_layer_q, vid_layer_d;
  logic [IDX_W-1:0]  vid_index_q, vid_index_d;
  logic              line_busy_q, line_busy_d;
  logic              valid_q, valid_d;
  burst_cmd_t        cmd_q, cmd_d;
  logic              line_done_q, line_done_d;
  logic              audio_grant_q, audio_grant_d;
  logic              flip_done_q, flip_done_d;
  logic              cur_bank_q, cur_bank_d;
  logic              flip_pend_q, flip_pend_d;
  logic              line_err_q, line_err_d;

  logic accept, last_burst, issue_v, issue_a;
  logic [ADDR_W-1:0] burst_addr;

  // Next-state, command sequencing and bank flip control
  always_comb begin
    state_d       = state_q;
    line_d        = line_q;
    line_bank_d   = line_bank_q;
    vid_layer_d   = vid_layer_q;
    vid_index_d   = vid_index_q;
    line_busy_d   = line_busy_q;
    valid_d       = valid_q;
    cmd_d         = cmd_q;
    line_done_d   = 1'b0;
    audio_grant_d = 1'b0;
    flip_done_d   = 1'b0;
    cur_bank_d    = cur_bank_q;
    flip_pend_d   = flip_pend_q | flip_req;
    line_err_d    = line_err_q;
    issue_v       = 1'b0;
    issue_a       = 1'b0;

    accept     = line_req && !line_busy_q && (32'(line_num) < LINES);
    last_burst = vid_layer_q && (vid_index_q == IDX_W'(BURSTS_PER_LINE - 1));

    if (line_req && !accept) line_err_d = 1'b1;

    // Snapshot line and bank so a later flip cannot affect this line
    if (accept) begin
      line_d      = line_num;
      line_bank_d = cur_bank_q;
      line_busy_d = 1'b1;
      vid_layer_d = 1'b0;
      vid_index_d = '0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = V_ISSUE;
          issue_v = 1'b1;
        end else if (audio_req && !line_req) begin
          state_d = A_ISSUE;
          issue_a = 1'b1;
        end
      end
      V_ISSUE: begin
        if (bus.burst_ready) begin
          valid_d = 1'b0;
          state_d = V_WAIT;
        end
      end
      A_ISSUE: begin
        if (bus.burst_ready) begin
          valid_d       = 1'b0;
          audio_grant_d = 1'b1;
          state_d       = A_WAIT;
        end
      end
      V_WAIT: begin
        if (bus.burst_done) begin
          if (last_burst) begin
            line_done_d = 1'b1;
            line_busy_d = 1'b0;
            state_d     = IDLE;
          end else begin
            if (vid_index_q == IDX_W'(BURSTS_PER_LINE - 1)) begin
              vid_layer_d = 1'b1;
              vid_index_d = '0;
            end else begin
              vid_index_d = vid_index_q + IDX_W'(1);
            end
            // One audio slot per gap between video bursts
            if (audio_req) begin
              state_d = A_ISSUE;
              issue_a = 1'b1;
            end else begin
              state_d = V_ISSUE;
              issue_v = 1'b1;
            end
          end
        end
      end
      A_WAIT: begin
        if (bus.burst_done) begin
          if (line_busy_d) begin
            state_d = V_ISSUE;
            issue_v = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue_v) begin
      valid_d = 1'b1;
      cmd_d   = '{is_audio: 1'b0, layer: vid_layer_d, index: vid_index_d, len: VIDEO_LEN};
    end else if (issue_a) begin
      valid_d = 1'b1;
      cmd_d   = '{is_audio: 1'b1, layer: 1'b0, index: '0, len: AUDIO_LEN};
    end

    if (frame_start && (flip_pend_q || flip_req)) begin
      cur_bank_d  = ~cur_bank_q;
      flip_done_d = 1'b1;
      flip_pend_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge m00_axi_aclk) begin
    if (m00_axi_areset) begin
      state_q       <= IDLE;
      line_q        <= '0;
      line_bank_q   <= 1'b0;
      vid_layer_q   <= 1'b0;
      vid_index_q   <= '0;
      line_busy_q   <= 1'b0;
      valid_q       <= 1'b0;
      cmd_q         <= '0;
      line_done_q   <= 1'b0;
      audio_grant_q <= 1'b0;
      flip_done_q   <= 1'b0;
      cur_bank_q    <= 1'b0;
      flip_pend_q   <= 1'b0;
      line_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      line_q        <= line_d;
      line_bank_q   <= line_bank_d;
      vid_layer_q   <= vid_layer_d;
      vid_index_q   <= vid_index_d;
      line_busy_q   <= line_busy_d;
      valid_q       <= valid_d;
      cmd_q         <= cmd_d;
      line_done_q   <= line_done_d;
      audio_grant_q <= audio_grant_d;
      flip_done_q   <= flip_done_d;
      cur_bank_q    <= cur_bank_d;
      flip_pend_q   <= flip_pend_d;
      line_err_q    <= line_err_d;
    end
  end

  fb_burst_addr_gen u_addr_gen (
    .clk        (m00_axi_aclk),
    .rst        (m00_axi_areset),
    .load       (issue_v | issue_a),
    .sel_audio  (issue_a),
    .audio_addr (audio_addr),
    .layer      (vid_layer_d),
    .bank       (line_bank_d),
    .line       (line_d),
    .index      (vid_index_d),
    .addr       (burst_addr)
  );

  assign bus.burst_valid    = valid_q;
  assign bus.burst_addr     = burst_addr;
  assign bus.burst_len      = cmd_q.len;
  assign bus.burst_layer    = cmd_q.layer;
  assign bus.burst_index    = cmd_q.index;
  assign bus.burst_is_audio = cmd_q.is_audio;
  assign audio_grant        = audio_grant_q;
  assign line_busy          = line_busy_q;
  assign line_done          = line_done_q;
  assign cur_bank           = cur_bank_q;
  assign flip_done          = flip_done_q;
  assign line_err           = line_err_q;

endmodule

// File: tb/tb_fb_line_fetch_scheduler.sv
// Directed bench for fb_line_fetch_scheduler with a burst engine model that
// logs every accepted command and returns burst_done 4 cycles later.
module tb_fb_line_fetch_scheduler;
  import fbreader_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        line_req = 1'b0;
  logic [8:0]  line_num = '0;
  logic        frame_start = 1'b0;
  logic        flip_req = 1'b0;
  logic        audio_req = 1'b0;
  logic [31:0] audio_addr = 32'h80F0_0000;
  logic        audio_grant, line_busy, line_done, cur_bank, flip_done, line_err;
  logic        ready_en = 1'b1;
  logic        done_r = 1'b0;

  fb_line_fetch_scheduler_if bus ();
  assign bus.burst_ready = ready_en;
  assign bus.burst_done  = done_r;

  fb_line_fetch_scheduler dut (
    .m00_axi_aclk   (clk),
    .m00_axi_areset (rst),
    .line_req       (line_req),
    .line_num       (line_num),
    .frame_start    (frame_start),
    .flip_req       (flip_req),
    .bus            (bus),
    .audio_req      (audio_req),
    .audio_addr     (audio_addr),
    .audio_grant    (audio_grant),
    .line_busy      (line_busy),
    .line_done      (line_done),
    .cur_bank       (cur_bank),
    .flip_done      (flip_done),
    .line_err       (line_err)
  );

  // Burst engine model and pulse counters
  logic        pend = 1'b0;
  logic [2:0]  dly = '0;
  logic [31:0] log_addr[$];
  logic [7:0]  log_len[$];
  logic        log_layer[$];
  logic [2:0]  log_idx[$];
  logic        log_aud[$];
  int unsigned grant_cnt = 0;
  int unsigned done_cnt = 0;

  always @(posedge clk) begin
    done_r <= 1'b0;
    if (rst) begin
      pend <= 1'b0;
      dly  <= '0;
    end else begin
      if (pend) begin
        if (dly == 3'd1) begin
          done_r <= 1'b1;
          pend   <= 1'b0;
        end else begin
          dly <= dly - 3'd1;
        end
      end
      if (bus.burst_valid && bus.burst_ready) begin
        pend <= 1'b1;
        dly  <= 3'd4;
        log_addr.push_back(bus.burst_addr);
        log_len.push_back(bus.burst_len);
        log_layer.push_back(bus.burst_layer);
        log_idx.push_back(bus.burst_index);
        log_aud.push_back(bus.burst_is_audio);
      end
    end
    if (audio_grant) grant_cnt <= grant_cnt + 1;
    if (line_done)   done_cnt  <= done_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_addr(input logic layer, input logic bank,
                                             input int unsigned line, input int unsigned idx);
    logic [31:0] b;
    if (!bank) b = layer ? 32'h8112_C000 : 32'h8100_0000;
    else       b = layer ? 32'h8138_4000 : 32'h8125_8000;
    return b + 32'(line) * 32'hA00 + 32'(idx) * 32'h200;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Request is held for one clock; returns at the negedge after acceptance
  task automatic pulse_line(input int unsigned n);
    @(negedge clk);
    line_num = 9'(n);
    line_req = 1'b1;
    @(negedge clk);
    line_req = 1'b0;
  endtask

  task automatic wait_line_done(input int unsigned d0);
    for (int i = 0; i < 600 && done_cnt == d0; i++) @(negedge clk);
    chk("line_done_count", 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic check_line(input string tag, input int base, input int unsigned line, input logic bank);
    chk({tag, "_ncmd"}, 32'(log_addr.size() - base), 32'd10);
    for (int k = 0; k < 10; k++) begin
      if (base + k < log_addr.size()) begin
        chk({tag, "_addr"},  log_addr[base+k], model_addr(1'(k / 5), bank, line, k % 5));
        chk({tag, "_layer"}, 32'(log_layer[base+k]), 32'(k / 5));
        chk({tag, "_index"}, 32'(log_idx[base+k]), 32'(k % 5));
        chk({tag, "_len"},   32'(log_len[base+k]), 32'd63);
        chk({tag, "_aud"},   32'(log_aud[base+k]), 32'd0);
      end
    end
  endtask

  initial begin
    int base;
    int unsigned d0, g0;

    // Reset state
    do_reset();
    chk("rst_valid", 32'(bus.burst_valid), 32'd0);
    chk("rst_addr",  bus.burst_addr, 32'd0);
    chk("rst_busy",  32'(line_busy), 32'd0);
    chk("rst_bank",  32'(cur_bank), 32'd0);
    chk("rst_err",   32'(line_err), 32'd0);

    // Line 0, bank 0
    base = log_addr.size();
    d0 = done_cnt;
    pulse_line(0);
    chk("l0_busy",  32'(line_busy), 32'd1);
    chk("l0_valid", 32'(bus.burst_valid), 32'd1);
    chk("l0_addr0", bus.burst_addr, 32'h8100_0000);
    wait_line_done(d0);
    check_line("l0", base, 0, 1'b0);
    if (base + 9 < log_addr.size()) begin
      chk("l0_last_fb0", log_addr[base+4], 32'h8100_0800);
      chk("l0_last_fb1", log_addr[base+9], 32'h8112_C800);
    end
    @(negedge clk);
    chk("l0_idle_busy", 32'(line_busy), 32'd0);
    chk("l0_one_done",  32'(done_cnt - d0), 32'd1);

    // Bank flip; a repeated flip_req while pending must not double-toggle
    @(negedge clk); flip_req = 1'b1;
    @(negedge clk); flip_req = 1'b1;
    @(negedge clk); flip_req = 1'b0;
    chk("flip_pre_bank", 32'(cur_bank), 32'd0);
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    chk("flip_done_pulse", 32'(flip_done), 32'd1);
    chk("flip_bank",       32'(cur_bank), 32'd1);
    @(negedge clk);
    chk("flip_done_low", 32'(flip_done), 32'd0);
    frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    chk("flip_nopend_bank", 32'(cur_bank), 32'd1);
    chk("flip_nopend_done", 32'(flip_done), 32'd0);

    // Line 479 in bank 1
    base = log_addr.size();
    d0 = done_cnt;
    pulse_line(479);
    chk("l479_addr0", bus.burst_addr, 32'h8138_3600);
    wait_line_done(d0);
    check_line("l479", base, 479, 1'b1);
    if (base + 9 < log_addr.size()) begin
      chk("l479_last_addr",  log_addr[base+9], 32'h814A_FE00);
      chk("l479_last_layer", 32'(log_layer[base+9]), 32'd1);
      chk("l479_last_index", 32'(log_idx[base+9]), 32'd4);
    end

    // Audio interleave; line_req wins over simultaneous audio_req
    base = log_addr.size();
    d0 = done_cnt;
    g0 = grant_cnt;
    @(negedge clk);
    audio_addr = 32'h80F0_0000;
    audio_req  = 1'b1;
    line_num   = 9'd5;
    line_req   = 1'b1;
    @(negedge clk);
    line_req = 1'b0;
    chk("aud_first_is_video", 32'(bus.burst_is_audio), 32'd0);
    for (int i = 0; i < 600 && grant_cnt - g0 < 9; i++) @(negedge clk);
    audio_req = 1'b0;
    wait_line_done(d0);
    chk("aud_grants", 32'(grant_cnt - g0), 32'd9);
    chk("aud_ncmd",   32'(log_addr.size() - base), 32'd19);
    for (int k = 0; k < 19; k++) begin
      if (base + k < log_addr.size()) begin
        if (k % 2 == 0) begin
          chk("aud_v_addr", log_addr[base+k], model_addr(1'((k / 2) / 5), 1'b1, 5, (k / 2) % 5));
          chk("aud_v_kind", 32'(log_aud[base+k]), 32'd0);
          chk("aud_v_len",  32'(log_len[base+k]), 32'd63);
        end else begin
          chk("aud_a_addr",  log_addr[base+k], 32'h80F0_0000);
          chk("aud_a_kind",  32'(log_aud[base+k]), 32'd1);
          chk("aud_a_len",   32'(log_len[base+k]), 32'd15);
          chk("aud_a_layer", 32'(log_layer[base+k]), 32'd0);
          chk("aud_a_index", 32'(log_idx[base+k]), 32'd0);
        end
      end
    end

    // Overrun: line_req while busy is rejected, line 7 completes untouched
    chk("ovr_err_pre", 32'(line_err), 32'd0);
    base = log_addr.size();
    d0 = done_cnt;
    pulse_line(7);
    repeat (3) @(negedge clk);
    pulse_line(9);
    chk("ovr_err",  32'(line_err), 32'd1);
    chk("ovr_busy", 32'(line_busy), 32'd1);
    wait_line_done(d0);
    check_line("ovr", base, 7, 1'b1);
    repeat (10) @(negedge clk);
    chk("ovr_no_extra", 32'(log_addr.size() - base), 32'd10);
    chk("ovr_err_sticky", 32'(line_err), 32'd1);

    // Out-of-range line index from idle
    do_reset();
    chk("oor_err_clr", 32'(line_err), 32'd0);
    base = log_addr.size();
    pulse_line(480);
    chk("oor_err",   32'(line_err), 32'd1);
    chk("oor_busy",  32'(line_busy), 32'd0);
    chk("oor_valid", 32'(bus.burst_valid), 32'd0);
    repeat (20) @(negedge clk);
    chk("oor_no_cmd", 32'(log_addr.size() - base), 32'd0);

    // Back-pressure: command held stable while ready is low
    ready_en = 1'b0;
    base = log_addr.size();
    d0 = done_cnt;
    pulse_line(1);
    for (int i = 0; i < 20; i++) begin
      chk("bp_valid", 32'(bus.burst_valid), 32'd1);
      chk("bp_addr",  bus.burst_addr, 32'h8100_0A00);
      @(negedge clk);
    end
    chk("bp_no_hs", 32'(log_addr.size() - base), 32'd0);
    ready_en = 1'b1;
    @(negedge clk);
    chk("bp_valid_drop", 32'(bus.burst_valid), 32'd0);
    chk("bp_one_hs", 32'(log_addr.size() - base), 32'd1);
    wait_line_done(d0);
    check_line("bp", base, 1, 1'b0);

    // Reset while waiting on the third burst, then restart with line 2
    base = log_addr.size();
    d0 = done_cnt;
    pulse_line(3);
    for (int i = 0; i < 300 && log_addr.size() < base + 3; i++) @(negedge clk);
    chk("mid_three_hs", 32'(log_addr.size() - base), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_valid", 32'(bus.burst_valid), 32'd0);
    chk("mid_addr",  bus.burst_addr, 32'd0);
    chk("mid_len",   32'(bus.burst_len), 32'd0);
    chk("mid_busy",  32'(line_busy), 32'd0);
    chk("mid_bank",  32'(cur_bank), 32'd0);
    repeat (10) @(negedge clk);
    chk("mid_abandon_cmd",  32'(log_addr.size() - base), 32'd3);
    chk("mid_abandon_done", 32'(done_cnt - d0), 32'd0);
    base = log_addr.size();
    d0 = done_cnt;
    pulse_line(2);
    chk("mid_restart_addr", bus.burst_addr, 32'h8100_1400);
    wait_line_done(d0);
    check_line("mid", base, 2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
